serial_code_sender: RTL and testbench
=====================================

# serial_code_sender

Transmitter side of the serial unlock interface. Accepts a parallel code word, shifts it out MSB-first over the `serial_data`/`serial_valid`/`serial_ready` handshake, and then waits for the lock's `unlock` or `pwd_incorrect` response. It reports pass, fail or timeout to the host, and sits between host/keypad logic and the lock FSM.

## Interface
- `CODE_WIDTH`, default 4: number of code bits sent per attempt; must be ≥ 1.
- `RESULT_TIMEOUT`, default 8: maximum cycles spent in WAIT_RESULT before declaring timeout; must be ≥ 1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to send `code_in`; sampled only in IDLE.
- `code_in`  in  CODE_WIDTH  code to send, captured when `start` is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when an attempt finishes.
- `result_pass`  out  1  last attempt unlocked; sticky until the next accepted `start`.
- `result_fail`  out  1  last attempt rejected; sticky until the next accepted `start`.
- `result_timeout`  out  1  last attempt got no response; sticky until the next accepted `start`.
- `serial_data`  out  1  current code bit.
- `serial_valid`  out  1  `serial_data` is valid.
- `serial_ready`  in  1  lock accepts a bit this cycle.
- `unlock`  in  1  lock response: correct code.
- `pwd_incorrect`  in  1  lock response: wrong code.

## Operation
- States: IDLE, SEND, WAIT_RESULT, DONE. The state register and all outputs are registered.
- Reset (asynchronous, `reset_n`=0):
  - state = IDLE.
  - `busy`, `done`, `serial_valid`, `serial_data` and all result flags = 0.
  - Shift register, bit counter and timeout counter cleared.
- IDLE:
  - On `start`=1, load the shift register with `code_in`, clear the bit counter and all result flags, then go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `serial_valid`=1 and `serial_data` = shift register MSB.
  - A bit transfers on an edge where `serial_valid` && `serial_ready`. On each transfer, shift left and increment the bit counter.
  - While `serial_ready`=0, `serial_data` and `serial_valid` hold their values.
  - When the transfer of bit CODE_WIDTH-1 completes, go to WAIT_RESULT and clear the timeout counter.
  - If `pwd_incorrect`=1 is sampled in SEND (early rejection by the lock), abort: no transfer on that edge, set `result_fail`, go to DONE.
- WAIT_RESULT:
  - `serial_valid`=0.
  - Sample the responses each edge:
    - `pwd_incorrect`=1 → set `result_fail`, go to DONE. If `unlock` is also 1 on the same edge, `pwd_incorrect` wins.
    - Else `unlock`=1 → set `result_pass`, go to DONE.
    - Else, if timeout counter = RESULT_TIMEOUT-1 → set `result_timeout`, go to DONE.
    - Else increment the timeout counter.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. A `start` in DONE is ignored.
- A `start` in SEND or WAIT_RESULT is ignored, and `code_in` changes have no effect after capture.
- Counter widths:
  - Bit counter: $clog2(CODE_WIDTH+1) bits.
  - Timeout counter: $clog2(RESULT_TIMEOUT+1) bits. It never wraps, because the timeout compare fires first.
- Exactly one result flag is set after each completed attempt.

## Timing
- Cycle reference: E0 is the edge at which `start` is accepted.
- `serial_valid` rises after E0.
- With `serial_ready` held high, bits transfer at E1..E_CODE_WIDTH.
- WAIT_RESULT begins after E_CODE_WIDTH.
- A response present in the cycle after the last transfer is sampled at E_CODE_WIDTH+1. `done` and the result flag are then high after that edge.
- Minimum attempt length is CODE_WIDTH+3 cycles from `start` until IDLE.
- Timeout with no response: `done` is asserted RESULT_TIMEOUT cycles after entering WAIT_RESULT.
- Reset asserted mid-SEND or mid-WAIT_RESULT: outputs drop to their reset values immediately (asynchronously). No partial result is reported.

## Test plan
- Code 4'b1011, `serial_ready` tied 1, lock model asserts `unlock` after the 4th transfer:
  - Bits 1,0,1,1 transfer at E1..E4.
  - `done`=1 and `result_pass`=1 after E5.
  - `busy` falls after E6.
- Code 4'b0011, lock asserts `pwd_incorrect` and drops `serial_ready` after E1:
  - Exactly one bit transfers.
  - Abort at E2, with `result_fail`=1 and `done` after E2.
  - `serial_valid`=0 from DONE onward.
- Backpressure: code 4'b1011, `serial_ready`=0 for 3 cycles before the 3rd bit:
  - `serial_data`=1 and `serial_valid`=1 held stable throughout.
  - The 4th bit transfers at E7.
  - `result_pass` follows.
- No response, RESULT_TIMEOUT=8:
  - `result_timeout`=1 and a `done` pulse exactly 8 cycles after WAIT_RESULT entry.
  - `result_pass` and `result_fail` stay 0.
- `start` pulsed during SEND, WAIT_RESULT and DONE with different `code_in` values:
  - Ignored; the original code is transmitted.
  - A new `start` in IDLE clears the sticky flags.
- `reset_n` pulsed low after the 2nd transfer:
  - All outputs go to 0 immediately and the state is IDLE.
  - A subsequent attempt completes normally with all 4 bits sent.

Source files
------------

// File: rtl/serial_code_sender.sv
// Transmitter for the serial unlock interface: shifts a code word out MSB-first
// over a valid/ready handshake, then waits for the lock's verdict or a timeout.
//
// state  | meaning
// IDLE   | waiting for start; result flags hold the last verdict
// SEND   | presenting code bits, one per valid&&ready edge
// WAIT   | code fully sent, waiting for unlock / pwd_incorrect / timeout
// DONE   | one-cycle done pulse, then back to IDLE
module serial_code_sender #(
    parameter int CODE_WIDTH     = 4,
    parameter int RESULT_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CODE_WIDTH-1:0] code_in,
    output logic                  busy,
    output logic                  done,
    output logic                  result_pass,
    output logic                  result_fail,
    output logic                  result_timeout,
    output logic                  serial_data,
    output logic                  serial_valid,
    input  logic                  serial_ready,
    input  logic                  unlock,
    input  logic                  pwd_incorrect
);

    localparam int BCW = $clog2(CODE_WIDTH + 1);
    localparam int TCW = $clog2(RESULT_TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(CODE_WIDTH - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(RESULT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CODE_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  data_q, data_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  tmo_q, tmo_d;

    logic xfer;
    logic last_bit;
    logic tmo_hit;

    // An early rejection pre-empts the bit that would otherwise transfer.
    assign xfer     = (state_q == S_SEND) && valid_q && serial_ready && !pwd_incorrect;
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign tmo_hit  = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SEND;
            S_SEND: begin
                if (pwd_incorrect)        state_d = S_DONE;
                else if (xfer && last_bit) state_d = S_WAIT;
            end
            S_WAIT: if (pwd_incorrect || unlock || tmo_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = code_in;
                    bit_cnt_d = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    tmo_d     = 1'b0;
                end
            end
            S_SEND: begin
                if (pwd_incorrect) begin
                    fail_d = 1'b1;
                end else if (xfer) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (last_bit) tmo_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // pwd_incorrect outranks unlock when both arrive together.
                if (pwd_incorrect)  fail_d    = 1'b1;
                else if (unlock)    pass_d    = 1'b1;
                else if (tmo_hit)   tmo_d     = 1'b1;
                else                tmo_cnt_d = tmo_cnt_q + TCW'(1);
            end
            default: ;
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        valid_d = (state_d == S_SEND);
        data_d  = valid_d ? shift_d[CODE_WIDTH-1] : 1'b0;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign serial_valid   = valid_q;
    assign serial_data    = data_q;
    assign result_pass    = pass_q;
    assign result_fail    = fail_q;
    assign result_timeout = tmo_q;

endmodule

// File: tb/tb_serial_code_sender.sv
// Bench for serial_code_sender: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of an unlock attempt.
module tb_serial_code_sender;

    localparam int CW = 4;
    localparam int RT = 8;
    localparam int P_IDLE = 0;
    localparam int P_SEND = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic          serial_ready = 1'b0;
    logic          unlock = 1'b0;
    logic          pwd_incorrect = 1'b0;
    logic          busy, done, result_pass, result_fail, result_timeout;
    logic          serial_data, serial_valid;

    int n_checks = 0;
    int n_fail = 0;

    serial_code_sender #(.CODE_WIDTH(CW), .RESULT_TIMEOUT(RT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .code_in(code_in),
        .busy(busy),
        .done(done),
        .result_pass(result_pass),
        .result_fail(result_fail),
        .result_timeout(result_timeout),
        .serial_data(serial_data),
        .serial_valid(serial_valid),
        .serial_ready(serial_ready),
        .unlock(unlock),
        .pwd_incorrect(pwd_incorrect)
    );

    always #5 clk = ~clk;

    // Model: remaining bits to send as a queue, cycles spent waiting, verdict flags.
    int m_phase;
    bit m_bits[$];
    int m_waited;
    bit m_pass, m_fail, m_to;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_bits.delete();
        m_waited = 0;
        m_pass = 0;
        m_fail = 0;
        m_to = 0;
    endfunction

    function automatic void model_step(bit st, logic [CW-1:0] code, bit rdy, bit unl, bit pwd);
        case (m_phase)
            P_IDLE: if (st) begin
                m_bits.delete();
                for (int i = CW - 1; i >= 0; i--) m_bits.push_back(code[i]);
                m_pass = 0; m_fail = 0; m_to = 0;
                m_phase = P_SEND;
            end
            P_SEND: begin
                if (pwd) begin
                    m_fail = 1;
                    m_phase = P_DONE;
                end else if (rdy) begin
                    void'(m_bits.pop_front());
                    if (m_bits.size() == 0) begin
                        m_waited = 0;
                        m_phase = P_WAIT;
                    end
                end
            end
            P_WAIT: begin
                if (pwd) begin
                    m_fail = 1; m_phase = P_DONE;
                end else if (unl) begin
                    m_pass = 1; m_phase = P_DONE;
                end else begin
                    m_waited++;
                    if (m_waited == RT) begin
                        m_to = 1; m_phase = P_DONE;
                    end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endfunction

    task automatic chk(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("busy", busy, m_phase != P_IDLE);
        chk("done", done, m_phase == P_DONE);
        chk("serial_valid", serial_valid, m_phase == P_SEND);
        if (m_phase == P_SEND) chk("serial_data", serial_data, m_bits[0]);
        chk("result_pass", result_pass, m_pass);
        chk("result_fail", result_fail, m_fail);
        chk("result_timeout", result_timeout, m_to);
    endtask

    // Called at a negedge: drive inputs, advance model, clock once, compare.
    task automatic cyc(bit st, logic [CW-1:0] code, bit rdy, bit unl, bit pwd);
        start = st; code_in = code; serial_ready = rdy; unlock = unl; pwd_incorrect = pwd;
        model_step(st, code, rdy, unl, pwd);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", serial_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", result_pass, 1'b0);
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_valid", serial_valid, 1'b0);
        chk("reset_data", serial_data, 1'b0);
        chk("reset_flags", result_pass | result_fail | result_timeout, 1'b0);
        reset_n = 1'b1;
        idle(2);

        // Pass case: 1011, ready tied high, unlock after the 4th transfer.
        cyc(1, 4'b1011, 1, 0, 0);
        chk("t1_e0_valid", serial_valid, 1'b1);
        chk("t1_e0_data", serial_data, 1'b1);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t1_e1_data", serial_data, 1'b0);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t1_e2_data", serial_data, 1'b1);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t1_e3_data", serial_data, 1'b1);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t1_e4_valid", serial_valid, 1'b0);
        cyc(0, 4'b0000, 1, 1, 0);
        chk("t1_e5_done", done, 1'b1);
        chk("t1_e5_pass", result_pass, 1'b1);
        chk("t1_e5_busy", busy, 1'b1);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t1_e6_busy", busy, 1'b0);
        chk("t1_e6_done", done, 1'b0);
        chk("t1_e6_pass_sticky", result_pass, 1'b1);
        idle(2);

        // Early rejection after one transfer.
        cyc(1, 4'b0011, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t2_e1_data", serial_data, 1'b0);
        cyc(0, 4'b0000, 0, 0, 1);
        chk("t2_e2_done", done, 1'b1);
        chk("t2_e2_fail", result_fail, 1'b1);
        chk("t2_e2_pass", result_pass, 1'b0);
        chk("t2_e2_valid", serial_valid, 1'b0);
        cyc(0, 4'b0000, 0, 0, 0);
        chk("t2_e3_valid", serial_valid, 1'b0);
        chk("t2_e3_fail_sticky", result_fail, 1'b1);
        idle(2);

        // Backpressure before the 3rd bit.
        cyc(1, 4'b1011, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 4'b0000, 0, 0, 0);
            chk("t3_hold_data", serial_data, 1'b1);
            chk("t3_hold_valid", serial_valid, 1'b1);
        end
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t3_e6_valid", serial_valid, 1'b1);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("t3_e7_valid", serial_valid, 1'b0);
        cyc(0, 4'b0000, 0, 1, 0);
        chk("t3_pass", result_pass, 1'b1);
        idle(2);

        // No response: timeout exactly RT cycles after entering the wait.
        cyc(1, 4'b0110, 1, 0, 0);
        for (int k = 0; k < CW; k++) cyc(0, 4'b0000, 1, 0, 0);
        for (int k = 1; k <= RT; k++) begin
            cyc(0, 4'b0000, 0, 0, 0);
            chk("t4_done", done, k == RT);
            chk("t4_timeout", result_timeout, k == RT);
        end
        chk("t4_pass", result_pass, 1'b0);
        chk("t4_fail", result_fail, 1'b0);
        idle(2);

        // Starts during SEND / WAIT / DONE are ignored.
        cyc(1, 4'b1011, 1, 0, 0);
        cyc(1, 4'b0100, 1, 0, 0);
        chk("t5_e1_data", serial_data, 1'b0);
        cyc(1, 4'b0111, 1, 0, 0);
        chk("t5_e2_data", serial_data, 1'b1);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(1, 4'b0110, 0, 0, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        cyc(1, 4'b0001, 0, 0, 0);
        chk("t5_done_start_busy", busy, 1'b0);
        chk("t5_done_start_pass", result_pass, 1'b1);
        cyc(1, 4'b1000, 0, 0, 0);
        chk("t5_newstart_pass_clr", result_pass, 1'b0);
        chk("t5_newstart_data", serial_data, 1'b1);
        for (int k = 0; k < CW; k++) cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        chk("t5_fail", result_fail, 1'b1);
        idle(2);

        // Async reset after the 2nd transfer, then a clean attempt.
        cyc(1, 4'b1101, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        pulse_reset();
        check_outputs();
        cyc(1, 4'b1001, 1, 0, 0);
        for (int k = 0; k < CW; k++) cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        chk("t6_pass", result_pass, 1'b1);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
                check_outputs();
            end else begin
                cyc($urandom_range(0, 3) == 0, CW'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
